// File: rtl/buzzer_seq_if.sv
// ---------------------------------------------------------------------------
// buzzer_seq_if
//    Groups the request/config inputs and the status outputs of the beep
//    sequencer into one bundle.
//    master : the requesting side (timebase/display logic or a testbench)
//    slave  : the sequencer itself
// Signals
//    trig        per-channel 1-cycle start pulse, index 0 = highest priority
//    stop        abort the sequence currently playing
//    half_period channel i tone half-period at [i*PW +: PW], 0 = silent burst
//    beep_cnt    channel i burst count at [i*CW +: CW], 0 = repeat forever
//    BUZZER      square-wave drive to the piezo
//    busy        high while a sequence is playing
//    active_ch   channel being played, meaningful while busy
//    done        1-cycle pulse when a sequence completes on its own
// ---------------------------------------------------------------------------
interface buzzer_seq_if #(
   parameter int N_CH = 2,
   parameter int PW   = 18,
   parameter int CW   = 4
);
   localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH-1:0]    trig;
   logic               stop;
   logic [N_CH*PW-1:0] half_period;
   logic [N_CH*CW-1:0] beep_cnt;
   logic               BUZZER;
   logic               busy;
   logic [AW-1:0]      active_ch;
   logic               done;

   modport master (
      output trig,
      output stop,
      output half_period,
      output beep_cnt,
      input  BUZZER,
      input  busy,
      input  active_ch,
      input  done
   );

   modport slave (
      input  trig,
      input  stop,
      input  half_period,
      input  beep_cnt,
      output BUZZER,
      output busy,
      output active_ch,
      output done
   );
endinterface

// File: rtl/buzzer_seq.sv
// ---------------------------------------------------------------------------
// buzzer_seq
//    Multi-channel beep sequencer owning the single piezo pin. Each request
//    channel starts a cadence of tone bursts: an ON slot playing a square wave
//    of the channel's half-period, followed by a silent OFF slot, repeated for
//    the channel's burst count (or forever when the count is 0). Lower channel
//    index wins and may pre-empt a running lower-priority sequence.
// Ports
//    CLK   system clock
//    nRST  asynchronous reset, active-low
//    bus   buzzer_seq_if slave modport (requests, config, BUZZER and status)
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module buzzer_seq #(
   parameter int N_CH     = 2,
   parameter int PW       = 18,
   parameter int CW       = 4,
   parameter int SLOT_CYC = 12000000,
   parameter int SW       = 24
) (
   input  logic          CLK,
   input  logic          nRST,
   buzzer_seq_if.slave   bus
);

   localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CYC - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] hp_q, hp_d;
   logic [PW-1:0] tone_q, tone_d;
   logic [CW-1:0] rem_q, rem_d;
   logic          inf_q, inf_d;
   logic [SW-1:0] slot_q, slot_d;
   logic          buzz_q, buzz_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [AW-1:0] ach_q, ach_d;

   logic          trigAny;
   logic [AW-1:0] winner;
   logic [PW-1:0] hpSel;
   logic [CW-1:0] cntSel;
   logic          accept;
   logic          slotLast;

   // Pick the lowest-index trig bit as the winner. Scanning from the top down
   // lets the last assignment (lowest index) take effect. A new request is
   // accepted when idle, or when it is the same or a higher-priority channel
   // than the one playing, which covers both restart and pre-emption.
   always_comb begin
      trigAny = |bus.trig;
      winner  = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (bus.trig[i]) begin
            winner = AW'(i);
         end
      end
      hpSel    = bus.half_period[winner*PW +: PW];
      cntSel   = bus.beep_cnt[winner*CW +: CW];
      accept   = trigAny && ((state_q == IDLE) || (winner <= ach_q));
      slotLast = (slot_q == SLOT_LAST);
   end

   // State register and all datapath registers. Config is only captured on an
   // accepted request, so later changes on the config inputs are ignored.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         hp_q    <= '0;
         tone_q  <= '0;
         rem_q   <= '0;
         inf_q   <= 1'b0;
         slot_q  <= '0;
         buzz_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ach_q   <= '0;
      end else begin
         state_q <= state_d;
         hp_q    <= hp_d;
         tone_q  <= tone_d;
         rem_q   <= rem_d;
         inf_q   <= inf_d;
         slot_q  <= slot_d;
         buzz_q  <= buzz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ach_q   <= ach_d;
      end
   end

   // Next-state logic. stop has absolute priority over any trig in the same
   // cycle. An accepted request always restarts tone and slot timing from zero
   // with BUZZER low, so a restart can never stretch a high phase. The last
   // cycle of an ON slot forces BUZZER low even if the tone would toggle then.
   // The infinite flag remembers a zero burst count, since rem_q alone cannot
   // tell "exhausted" from "repeat forever".
   always_comb begin
      state_d = state_q;
      hp_d    = hp_q;
      tone_d  = tone_q;
      rem_d   = rem_q;
      inf_d   = inf_q;
      slot_d  = slot_q;
      buzz_d  = buzz_q;
      done_d  = 1'b0;
      ach_d   = ach_q;

      if (bus.stop) begin
         state_d = IDLE;
         buzz_d  = 1'b0;
         tone_d  = '0;
         slot_d  = '0;
      end else if (accept) begin
         hp_d    = hpSel;
         rem_d   = cntSel;
         inf_d   = (cntSel == '0);
         ach_d   = winner;
         state_d = ON;
         tone_d  = '0;
         slot_d  = '0;
         buzz_d  = 1'b0;
      end else begin
         case (state_q)
            ON: begin
               if (slotLast) begin
                  state_d = OFF;
                  slot_d  = '0;
                  tone_d  = '0;
                  buzz_d  = 1'b0;
                  if (rem_q != '0) begin
                     rem_d = rem_q - 1'b1;
                  end
               end else begin
                  slot_d = slot_q + 1'b1;
                  if (hp_q == '0) begin
                     buzz_d = 1'b0;
                     tone_d = '0;
                  end else if (tone_q == (hp_q - 1'b1)) begin
                     buzz_d = ~buzz_q;
                     tone_d = '0;
                  end else begin
                     tone_d = tone_q + 1'b1;
                  end
               end
            end
            OFF: begin
               buzz_d = 1'b0;
               if (slotLast) begin
                  slot_d = '0;
                  tone_d = '0;
                  if (!inf_q && (rem_q == '0)) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = ON;
                  end
               end else begin
                  slot_d = slot_q + 1'b1;
               end
            end
            default: begin
               buzz_d = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != IDLE);
   end

   // Outputs are driven directly from registers.
   always_comb begin
      bus.BUZZER    = buzz_q;
      bus.busy      = busy_q;
      bus.active_ch = ach_q;
      bus.done      = done_q;
   end

endmodule
